fr_rate_mon: RTL and testbench
==============================

FR_RATE_MON -- requirements
Module: fr_rate_mon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of monitored count and of the rate result.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 100000000, length of one measurement window in clk cycles; legal range is at least 2.
REQ-003 SHALL have parameter DROP_WIDTH, default 16, width of the dropped-result counter.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port en_in, input, 1 bit: monitor enable; level sensitive.
REQ-007 SHALL have port cnt_in, input, DATA_WIDTH bits: free-running, wrapping event count from an upstream frame counter in the clk domain.
REQ-008 SHALL have port rate_out, output, DATA_WIDTH bits: count delta over one window.
REQ-009 SHALL have port rate_valid_out, output, 1 bit: rate_out holds an unaccepted result.
REQ-010 SHALL have port rate_ready_in, input, 1 bit: consumer accepts rate_out when high together with rate_valid_out.
REQ-011 SHALL have port drop_cnt_out, output, DROP_WIDTH bits: results discarded because of backpressure.
REQ-012 SHALL have port busy_out, output, 1 bit: high while state is MEASURE.

Function
REQ-013 SHALL implement the states IDLE and MEASURE.
REQ-014 IDLE with en_in=1 at cycle t SHALL capture base=cnt_in(t), load the window timer with WINDOW_CYCLES-1, and enter MEASURE at t+1.
REQ-015 In MEASURE, the window timer SHALL decrement by 1 per cycle.
REQ-016 When the window timer is 0 in MEASURE (cycle t+WINDOW_CYCLES), SHALL compute delta=(cnt_in-base) mod 2^DATA_WIDTH, set base=cnt_in, and reload the timer with WINDOW_CYCLES-1; windows are back-to-back with no gap cycles.
REQ-017 Delta arithmetic SHALL be DATA_WIDTH-bit unsigned; a single counter wrap within a window yields the correct delta.
REQ-018 A delta SHALL appear on rate_out with rate_valid_out=1 in the cycle after the window end, provided the output register is free.
REQ-019 The output register SHALL be free when rate_valid_out=0, or when rate_valid_out=1 and rate_ready_in=1 in the same cycle.
REQ-020 While rate_valid_out=1 and rate_ready_in=0, rate_out SHALL remain stable; a new delta produced then SHALL be discarded, and drop_cnt_out SHALL increment, saturating at all-ones.
REQ-021 On a handshake with no new delta, rate_valid_out SHALL deassert in the next cycle.
REQ-022 en_in=0 in MEASURE SHALL abort to IDLE in the next cycle.
REQ-022a On abort, the partial window SHALL be discarded with no result.
REQ-022b On abort, a pending result SHALL stay valid until accepted.
REQ-023 en_in=0 in the window-end cycle SHALL still produce that window's delta, then go to IDLE.
REQ-024 Re-enable from IDLE SHALL start a fresh window per REQ-014.
REQ-025 rate_valid_out SHALL be independent of rate_ready_in, with no combinational path from ready to valid.

Reset
REQ-026 While rst_n=0 at a clk edge, the state SHALL be IDLE.
REQ-027 While rst_n=0 at a clk edge, rate_out, base, the timer and drop_cnt_out SHALL be 0.
REQ-028 While rst_n=0 at a clk edge, rate_valid_out and busy_out SHALL be 0.
REQ-029 Reset SHALL override all other inputs in that cycle, including a mid-window reset.
REQ-029a Any in-flight or pending result SHALL be lost on reset.

Structure
REQ-030 The shared package fr_pkg SHALL hold the state enum fr_mon_state_t (IDLE, MEASURE).
REQ-030a fr_pkg SHALL hold the default DATA_WIDTH and DROP_WIDTH constants.
REQ-031 The window timer SHALL be a separate sub-module, fr_win_timer, with inputs load, dec and outputs count and zero.
REQ-031a The timer width SHALL be $clog2(WINDOW_CYCLES).

Verification (WINDOW_CYCLES=8, DATA_WIDTH=32)
REQ-032 Steady rate: cnt_in +1 every cycle, en_in=1, ready=1 -> rate_out=8 every 8 cycles, drop_cnt_out=0.
REQ-033 Wrap: cnt_in starts at 0xFFFFFFFC and increments each cycle -> first rate_out=8.
REQ-034 Backpressure: ready=0 for 3 full windows with cnt_in +2 per cycle -> rate_out=16 held stable, drop_cnt_out=2; ready=1 -> one handshake, then valid drops.
REQ-035 Simultaneous events: handshake in the same cycle as a new window end -> new delta loaded, no drop.
REQ-036 Abort: en_in=0 after 5 MEASURE cycles -> IDLE next cycle, no rate_valid_out.
REQ-036a Abort follow-up: re-enable -> first result 8 cycles after the capture cycle.
REQ-037 Reset mid-window with rate_valid_out=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fr_pkg.sv
// Shared definitions for the frame-rate monitor: state encoding and default widths.
package fr_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fr_mon_state_t;

  localparam int unsigned FR_DATA_WIDTH = 32;
  localparam int unsigned FR_DROP_WIDTH = 16;

endpackage

// File: rtl/fr_win_timer.sv
// Down-counting window timer; load takes priority over decrement.
module fr_win_timer #(
  parameter int unsigned WIDTH      = 27,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fr_rate_mon.sv
// Measures the delta of a wrapping event counter over fixed back-to-back windows
// and presents each result through a valid/ready register with drop counting.
module fr_rate_mon
  import fr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FR_DATA_WIDTH,
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter int unsigned DROP_WIDTH    = FR_DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_in,
  input  logic [DATA_WIDTH-1:0] cnt_in,
  output logic [DATA_WIDTH-1:0] rate_out,
  output logic                  rate_valid_out,
  input  logic                  rate_ready_in,
  output logic [DROP_WIDTH-1:0] drop_cnt_out,
  output logic                  busy_out
);

  localparam int unsigned TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES - 1);

  fr_mon_state_t         state_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] delta;
  logic [TW-1:0]         tmr_count;
  logic                  tmr_zero;
  logic                  tmr_load;
  logic                  tmr_dec;
  logic                  win_end;
  logic                  out_free;

  assign win_end  = (state_q == MEASURE) && tmr_zero;
  assign tmr_load = ((state_q == IDLE) && en_in) || win_end;
  assign tmr_dec  = (state_q == MEASURE) && !tmr_zero;
  assign delta    = cnt_in - base_q;
  assign out_free = !rate_valid_out || rate_ready_in;
  assign busy_out = (state_q == MEASURE);

  fr_win_timer #(
    .WIDTH      (TW),
    .LOAD_VALUE (TIMER_LOAD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_in) begin
            base_q  <= cnt_in;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          // A window ending while disabled still yields its result.
          if (win_end) begin
            base_q <= cnt_in;
          end
          if (!en_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_out       <= '0;
      rate_valid_out <= 1'b0;
      drop_cnt_out   <= '0;
    end else if (win_end) begin
      if (out_free) begin
        rate_out       <= delta;
        rate_valid_out <= 1'b1;
      end else if (drop_cnt_out != '1) begin
        drop_cnt_out <= drop_cnt_out + 1'b1;
      end
    end else if (rate_valid_out && rate_ready_in) begin
      rate_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fr_rate_mon.sv
// Scoreboard bench for fr_rate_mon with an 8-cycle window: stimulus queues expected
// rates, a negedge monitor pops and compares on every handshake.
module tb_fr_rate_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [31:0] cnt_in;
  logic [31:0] rate_out;
  logic        rate_valid_out;
  logic        rate_ready_in;
  logic [15:0] drop_cnt_out;
  logic        busy_out;

  logic [31:0] stride;
  logic [31:0] exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fr_rate_mon #(
    .DATA_WIDTH    (32),
    .WINDOW_CYCLES (8),
    .DROP_WIDTH    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_in          (en_in),
    .cnt_in         (cnt_in),
    .rate_out       (rate_out),
    .rate_valid_out (rate_valid_out),
    .rate_ready_in  (rate_ready_in),
    .drop_cnt_out   (drop_cnt_out),
    .busy_out       (busy_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles; inputs change 1 time unit after each rising edge.
  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cnt_in = cnt_in + stride;
    end
  endtask

  // Monitor: a handshake at the coming edge consumes the oldest expected rate.
  always @(negedge clk) begin
    if (rst_n && rate_valid_out && rate_ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected none", rate_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rate_out !== e) begin
          errors++;
          $display("FAIL rate_out: got 0x%0h expected 0x%0h", rate_out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned lat;
    rst_n = 1'b0; en_in = 1'b0; cnt_in = '0; stride = 32'd1; rate_ready_in = 1'b1;
    cycles(2);
    chk("reset_rate", rate_out, 0);
    chk("reset_valid", rate_valid_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_drop", drop_cnt_out, 0);
    rst_n = 1'b1;
    cycles(2);

    // Steady rate: three windows, aborted before the fourth ends.
    cnt_in = 32'd100; stride = 32'd1; rate_ready_in = 1'b1;
    exp_q.push_back(32'd8); exp_q.push_back(32'd8); exp_q.push_back(32'd8);
    en_in = 1'b1;
    cycles(2);
    chk("busy_measure", busy_out, 1);
    cycles(28);
    en_in = 1'b0;
    cycles(3);
    chk("steady_drop", drop_cnt_out, 0);
    chk("steady_idle_busy", busy_out, 0);
    chk("steady_idle_valid", rate_valid_out, 0);

    // Counter wrap inside the window.
    cnt_in = 32'hFFFF_FFFC;
    exp_q.push_back(32'd8);
    en_in = 1'b1;
    cycles(12);
    en_in = 1'b0;
    cycles(3);
    chk("wrap_valid_after", rate_valid_out, 0);

    // Backpressure across three windows at stride 2.
    stride = 32'd2; rate_ready_in = 1'b0;
    en_in = 1'b1;
    for (int k = 0; k < 28; k++) begin
      cycles(1);
      if (rate_valid_out) chk("bp_stable", rate_out, 16);
    end
    chk("bp_valid_held", rate_valid_out, 1);
    chk("bp_drop", drop_cnt_out, 2);
    exp_q.push_back(32'd16);
    rate_ready_in = 1'b1; en_in = 1'b0;
    cycles(1);
    chk("bp_valid_drops", rate_valid_out, 0);
    chk("bp_drop_after", drop_cnt_out, 2);

    // Handshake coinciding with the next window end: second delta 16, no drop.
    cycles(2);
    stride = 32'd1; rate_ready_in = 1'b0;
    exp_q.push_back(32'd8); exp_q.push_back(32'd16);
    en_in = 1'b1;
    cycles(8);
    stride = 32'd2;
    cycles(8);
    rate_ready_in = 1'b1;
    cycles(1);
    chk("sim_valid_kept", rate_valid_out, 1);
    chk("sim_rate_new", rate_out, 16);
    cycles(3);
    en_in = 1'b0;
    cycles(2);
    chk("sim_drop", drop_cnt_out, 2);
    chk("sim_valid_after", rate_valid_out, 0);

    // Abort after five MEASURE cycles, then re-enable.
    stride = 32'd1;
    en_in = 1'b1;
    cycles(5);
    en_in = 1'b0;
    cycles(1);
    chk("abort_busy", busy_out, 0);
    cycles(10);
    chk("abort_no_valid", rate_valid_out, 0);
    chk("abort_queue_untouched", exp_q.size(), 0);
    exp_q.push_back(32'd8);
    en_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      if (rate_valid_out) begin
        lat = k;
        break;
      end
    end
    chk("reenable_latency", lat, 9);
    en_in = 1'b0;
    cycles(3);

    // Reset mid-window while a result is pending.
    rate_ready_in = 1'b0;
    en_in = 1'b1;
    cycles(12);
    chk("pre_reset_valid", rate_valid_out, 1);
    chk("pre_reset_busy", busy_out, 1);
    rst_n = 1'b0;
    cycles(1);
    chk("rst_rate", rate_out, 0);
    chk("rst_valid", rate_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_drop", drop_cnt_out, 0);
    en_in = 1'b0; rst_n = 1'b1;
    cycles(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
